// File: rtl/mac_stream_pkg.sv
// Shared defaults, result type and count-width helper for the MAC stream controller.
package mac_stream_pkg;

    localparam int BITS_DEF  = 32;
    localparam int LAT_DEF   = 4;
    localparam int DEPTH_DEF = 8;

    typedef logic [2*BITS_DEF-1:0] result_t;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous result FIFO with a registered head (rd_data/rd_valid) and occupancy count.
module mac_result_fifo
    import mac_stream_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = 2*BITS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic                        rd_valid,
    output logic [WIDTH-1:0]            rd_data,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             rd_valid_r;
    logic [WIDTH-1:0] rd_data_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic             pop_s;

    // Next pointer/count and the value that becomes the head after this edge.
    always_comb begin
        pop_s        = rd_en && rd_valid_r;
        rd_ptr_nxt_s = rd_ptr_r + PW'(pop_s);
        count_nxt_s  = count_r + CW'(wr_en) - CW'(pop_s);
        if (wr_en && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            wr_ptr_r   <= wr_ptr_r + PW'(wr_en);
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            rd_valid_r <= (count_nxt_s != '0);
            if (count_nxt_s != '0) begin
                rd_data_r <= head_nxt_s;
            end
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign count    = count_r;

    mac_result_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .count (count_r)
    );

endmodule

// File: rtl/mac_result_fifo_chk.sv
// Protocol checker for mac_result_fifo: a write must never land on a full FIFO.
module mac_result_fifo_chk #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          wr_en,
    input logic [CW-1:0] count
);

    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (rst) !(wr_en && (count == CW'(DEPTH)))
    ) else $error("mac_result_fifo: write while full");

endmodule

// File: rtl/mac_stream_ctrl.sv
// Valid/ready front-end and credit-protected result buffer for a fixed-latency MAC pipeline.
// Optional macro MAC_OPERAND_GATE_EN zeroes mac_a/mac_b/mac_ci in cycles without an accept.
module mac_stream_ctrl
    import mac_stream_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS-1:0]   in_a,
    input  logic [BITS-1:0]   in_b,
    input  logic [2*BITS-1:0] in_ci,
    output logic [BITS-1:0]   mac_a,
    output logic [BITS-1:0]   mac_b,
    output logic [2*BITS-1:0] mac_ci,
    input  logic [2*BITS-1:0] mac_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*BITS-1:0] out_data,
    output logic              busy
);

    localparam int CW = cnt_width(DEPTH);

    logic [LAT-1:0] vld_r;
    logic [CW-1:0]  fifo_count_s;
    logic [CW:0]    inflight_s;
    logic           fire_s;

    // Credits: everything in flight already owns a FIFO slot, so only registered state is used.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_s = inflight_s + (CW+1)'(vld_r[i]);
        end
        in_ready = (((CW+1)'(fifo_count_s) + inflight_s) < (CW+1)'(DEPTH));
        fire_s   = in_valid && in_ready;
    end

    // Operand drive toward the pipeline, sampled on the same edge as the accept.
    always_comb begin
`ifdef MAC_OPERAND_GATE_EN
        if (fire_s) begin
            mac_a  = in_a;
            mac_b  = in_b;
            mac_ci = in_ci;
        end else begin
            mac_a  = '0;
            mac_b  = '0;
            mac_ci = '0;
        end
`else
        mac_a  = in_a;
        mac_b  = in_b;
        mac_ci = in_ci;
`endif
    end

    // Token tracker mirroring the pipeline stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= '0;
        end else begin
            vld_r[0] <= fire_s;
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    mac_result_fifo #(.DEPTH(DEPTH), .WIDTH(2*BITS)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (vld_r[LAT-1]),
        .wr_data  (mac_o),
        .rd_en    (out_ready),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .count    (fifo_count_s)
    );

    assign busy = (|vld_r) || (fifo_count_s != '0);

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Self-checking bench for mac_stream_ctrl with a behavioural 4-stage multiply-add pipeline.
module tb_mac_stream_ctrl;

    localparam int BITS  = 32;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [BITS-1:0]   in_a;
    logic [BITS-1:0]   in_b;
    logic [2*BITS-1:0] in_ci;
    logic [BITS-1:0]   mac_a;
    logic [BITS-1:0]   mac_b;
    logic [2*BITS-1:0] mac_ci;
    logic [2*BITS-1:0] mac_o;
    logic              out_valid;
    logic              out_ready;
    logic [2*BITS-1:0] out_data;
    logic              busy;

    mac_stream_ctrl #(.BITS(BITS), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_ci    (mac_ci),
        .mac_o     (mac_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Unresettable pipeline: samples operands every edge, result on o after LAT-1 further edges.
    logic [2*BITS-1:0] pipe_r [LAT];
    always @(posedge clk) begin
        pipe_r[0] <= 64'(mac_a) * 64'(mac_b) + mac_ci;
        for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end
    assign mac_o = pipe_r[LAT-1];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] ci;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] sb_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int pops = 0;
    int accepts = 0;
    int cyc = 0;
    int pop_start = -1;
    int last_pop_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs are already set at a negedge; sample mid-low-phase, then advance.
    task automatic cycle();
        logic fire;
        logic gate_ok;
        #1;
        fire = in_valid && in_ready;
`ifdef MAC_OPERAND_GATE_EN
        if (fire) gate_ok = (mac_a == in_a) && (mac_b == in_b) && (mac_ci == in_ci);
        else      gate_ok = (mac_a == 32'd0) && (mac_b == 32'd0) && (mac_ci == 64'd0);
`else
        gate_ok = (mac_a == in_a) && (mac_b == in_b) && (mac_ci == in_ci);
`endif
        check("mac_operands", 64'(gate_ok), 64'd1);
        if (fire) begin
            sb_q.push_back(64'(in_a) * 64'(in_b) + in_ci);
            accepts++;
        end
        if (out_valid && out_ready) begin
            pops++;
            if (pop_start < 0) pop_start = cyc;
            last_pop_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_extra: got 0x%0h expected no output", out_data);
            end else begin
                check("sb_data", out_data, sb_q.pop_front());
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 400) begin
            cycle();
            n++;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] ci);
        in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        int w, p0, a0, guard;

        vecs[0] = '{32'd3, 32'd5, 64'd7, 64'd22};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFE_0000_0000};
        vecs[2] = '{32'd0, 32'd0, 64'd0, 64'd0};
        vecs[3] = '{32'd1, 32'h10, 64'd0, 64'h10};
        vecs[4] = '{32'h1_0000, 32'h1_0000, 64'd1, 64'h1_0000_0001};
        vecs[5] = '{32'd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd41};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_busy", 64'(busy), 64'd0);

        // Single-op table: latency, value, single pulse.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].ci);
            w = 1;
            while (!out_valid && w < 20) begin
                cycle();
                w++;
            end
            check("tbl_latency", 64'(w), 64'(LAT + 1));
            check("tbl_data", out_data, vecs[i].exp);
            cycle();
            check("tbl_pulse", 64'(out_valid), 64'd0);
        end

        // Back-to-back stream with no backpressure.
        p0 = pops; pop_start = -1;
        for (int i = 0; i < 100; i++) begin
            check("b2b_ready", 64'(in_ready), 64'd1);
            in_a = 32'(i); in_b = 32'(i + 1); in_ci = 64'(i); in_valid = 1'b1;
            cycle();
        end
        drain("b2b_drain");
        check("b2b_count", 64'(pops - p0), 64'd100);
        check("b2b_rate", 64'(last_pop_cyc - pop_start), 64'd99);

        // Backpressure fills exactly DEPTH credits.
        out_ready = 1'b0; a0 = accepts;
        for (int i = 0; i < 20; i++) begin
            in_a = 32'(i + 11); in_b = 32'(3 * i + 1); in_ci = 64'(i * 1000); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        check("bp_accepts", 64'(accepts - a0), 64'(DEPTH));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        p0 = pops;
        drain("bp_drain");
        check("bp_pops", 64'(pops - p0), 64'(DEPTH));
        check("bp_busy", 64'(busy), 64'd0);

        // Reset with 2 buffered and 3 in flight discards everything.
        out_ready = 1'b0;
        issue(32'd2, 32'd2, 64'd0);
        issue(32'd3, 32'd3, 64'd0);
        repeat (LAT + 2) cycle();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 32'(i + 20); in_b = 32'd4; in_ci = 64'd5;
            cycle();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        p0 = pops;
        repeat (LAT + 3) cycle();
        check("post_rst_quiet", 64'(pops - p0), 64'd0);
        issue(32'd9, 32'd9, 64'd1);
        drain("post_rst_drain");
        check("post_rst_pops", 64'(pops - p0), 64'd1);

        // Random valid/ready traffic.
        a0 = accepts; guard = 0;
        while ((accepts - a0) < 10000 && guard < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_a  = $urandom;
            in_b  = $urandom;
            in_ci = {$urandom, $urandom};
            cycle();
            guard++;
        end
        check("rand_accepts", 64'(accepts - a0), 64'd10000);
        drain("rand_drain");
        cycle();
        check("rand_busy", 64'(busy), 64'd0);
        check("rand_out_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_stream_ctrl.md
Name: mac_stream_ctrl

Overview:
Streaming front/back-end for the fixed-latency, unstallable multiply-add pipeline (o = a*b + ci, 4-cycle latency, no enable).
- Accepts operand triples on a valid/ready input, issues them to the pipeline and tracks in-flight tokens with a valid shift register.
- Captures results into a credit-protected result FIFO, so downstream backpressure never drops a result.
- Sits directly upstream of the pipeline's a/b/ci inputs and directly downstream of its o output.

Parameters:
- BITS, 32, operand width; results and ci are 2*BITS.
- LAT, 4, pipeline latency in clock edges from sampling a/b/ci to the result on o; must be >= 1.
- DEPTH, 8, result FIFO entries; must be >= LAT+2 for one-per-cycle throughput; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand triple valid.
- in_ready  out  1  controller can accept this cycle.
- in_a  in  BITS  multiplicand.
- in_b  in  BITS  multiplier.
- in_ci  in  2*BITS  addend.
- mac_a  out  BITS  to pipeline a.
- mac_b  out  BITS  to pipeline b.
- mac_ci  out  2*BITS  to pipeline ci.
- mac_o  in  2*BITS  from pipeline o.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_data  out  2*BITS  result, in issue order.
- busy  out  1  any token in flight or buffered.

Behaviour:
- Issue: fire = in_valid && in_ready, sampled at posedge. mac_a/b/ci = in_a/b/ci combinationally, so the pipeline samples them on the same edge.
- Tracking: vld[LAT-1:0] shift register; vld[0] <= fire, vld[i] <= vld[i-1].
  - A token issued at edge k has vld[LAT-1]=1 after edge k+LAT-1, when mac_o holds its result.
  - The FIFO writes mac_o at edge k+LAT.
- Latency: out_valid rises at the earliest after edge k+LAT (LAT+1 cycles after acceptance). There is no bypass; out_data comes from a registered FIFO head.
- Credits: inflight = popcount(vld).
  - in_ready = (fifo_count + inflight) < DEPTH, computed from registered state only.
  - There is no combinational path from out_ready to in_ready. A pop frees a credit from the next cycle.
- FIFO write is guaranteed never to occur when full; an assertion fires if it does.
- Simultaneous write and pop: when the FIFO is non-empty, count is unchanged. When it is empty, the write lands and out_valid rises next cycle.
- Pointers: wrap modulo DEPTH. fifo_count is 0..DEPTH, log2(DEPTH)+1 bits.
- Output handshake: while out_valid && !out_ready, out_data and out_valid are held stable.
- busy = |vld || fifo_count != 0.
- Reset (async assert, sync deassert expected upstream):
  - vld=0, pointers=0, fifo_count=0, out_valid=0, out_data=0, in_ready=1 after release, busy=0.
  - Results of tokens in flight at reset are discarded. The pipeline itself has no reset; its garbage output is ignored because vld=0.
- Width rule: the pipeline result is taken as-is at 2*BITS with no saturation; wrap-around is the pipeline's responsibility.
- Ordering: strictly FIFO; no reordering or drops.

Optional Feature:
- Macro: MAC_OPERAND_GATE_EN.
- Defined: mac_a, mac_b and mac_ci are forced to 0 in cycles without fire, to cut pipeline toggling. The pipeline's output for those cycles is ignored because vld=0.
- Not defined: mac_* pass in_* through unconditionally.
- Functional results are identical in both builds.

Decomposition:
- Package mac_stream_pkg holds:
  - default BITS/LAT/DEPTH constants;
  - result type (2*BITS vector);
  - count width function clog2(DEPTH)+1.
- One natural sub-module: mac_result_fifo, a synchronous FIFO with DEPTH, 2*BITS width, registered head, count output and async active-high reset.
- Credit logic and the vld shift register stay in the top.

Test Plan:
- Single op, a=3, b=5, ci=7 with out_ready=1 -> exactly one out_valid pulse, out_data=22, LAT+1 cycles after the accept edge.
- 100 back-to-back ops (a=i, b=i+1, ci=i) with out_ready=1 -> in_ready stays 1 throughout, outputs i*(i+1)+i in order, one per cycle.
- out_ready held 0 while in_valid=1 -> exactly DEPTH=8 accepts, then in_ready=0. Raising out_ready drains all 8 in order with no drops or duplicates.
- a=b=0xFFFFFFFF, ci=0xFFFFFFFFFFFFFFFF -> out_data=0xFFFFFFFE00000000 (wrapped 64-bit sum).
- Assert rst with 3 ops in flight and 2 buffered -> out_valid=0, busy=0 immediately. After release, the next op's result is the only output.
- Random valid/out_ready toggling (50%) for 10k ops, run with and without MAC_OPERAND_GATE_EN -> scoreboard matches a*b+ci in order. Under the macro, mac_a/b/ci=0 whenever fire=0.
